pwm_dac_out: RTL and testbench

Output stage that converts the 8-bit sample stream from the waveform generators into a single-bit PWM signal for the board's RC-filtered DAC pin. It double-buffers one sample, plays each sample for exactly one PWM period, and applies an optional power-of-two attenuation. A valid/ready handshake throttles the generator to one sample per PWM period, and underruns are flagged.

---
 rtl/pwm_dac_out_pkg.sv | 11 +
 rtl/pwm_dac_out_prescaler.sv | 36 +++
 rtl/pwm_dac_out.sv | 99 +++++++++
 tb/tb_pwm_dac_out.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_dac_out_pkg.sv
// Shared constants and helpers for the PWM DAC output stage.
package pwm_dac_out_pkg;

  localparam int AMP_SHIFT_W = 2;

  // Largest counter value; one PWM period spans pwm_max+1 ticks.
  function automatic int pwm_max(input int width);
    return (1 << width) - 2;
  endfunction

endpackage

// File: rtl/pwm_dac_out_prescaler.sv
// Clock divider for the PWM counter: emits a one-clk tick every PRESCALE enabled clks.
module pwm_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  output logic tick_o
);

  localparam int DIV_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PRESCALE - 1);

  logic [DIV_W-1:0] div_q, div_d;

  assign tick_o = en_i && (div_q == DIV_LAST);

  // div freezes while disabled so a paused period resumes mid-tick.
  always_comb begin
    div_d = div_q;
    if (tick_o) begin
      div_d = '0;
    end else if (en_i) begin
      div_d = div_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/pwm_dac_out.sv
// PWM DAC output stage: double-buffered sample, one sample per PWM period,
// power-of-two attenuation and sticky underrun detection.
module pwm_dac_out
  import pwm_dac_out_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       sample,
  input  logic                   sample_valid,
  output logic                   sample_ready,
  input  logic [AMP_SHIFT_W-1:0] amp_shift,
  input  logic                   enable,
  input  logic                   clr_underrun,
  output logic                   pwm_out,
  output logic                   period_start,
  output logic                   underrun
);

  localparam logic [WIDTH-1:0] MAX = WIDTH'(pwm_max(WIDTH));

  logic             tick;
  logic             boundary;
  logic             accept;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic [WIDTH-1:0] active_q, active_d;
  logic             pend_full_q, pend_full_d;
  logic             pwm_q, pwm_d;
  logic             ps_q, ps_d;
  logic             und_q, und_d;

  pwm_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .en_i   (enable),
    .tick_o (tick)
  );

  assign sample_ready = !pend_full_q;
  assign accept       = sample_valid && !pend_full_q;
  assign boundary     = tick && (cnt_q == MAX);

  always_comb begin
    cnt_d       = cnt_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    active_d    = active_q;
    if (tick) begin
      cnt_d = boundary ? '0 : cnt_q + WIDTH'(1);
    end
    // An accept can only coincide with a boundary when pend is empty, so
    // the two never fight over pend_full.
    if (accept) begin
      pend_d      = sample;
      pend_full_d = 1'b1;
    end
    if (boundary && pend_full_q) begin
      active_d    = pend_q >> amp_shift;
      pend_full_d = 1'b0;
    end
    pwm_d = enable && (active_q > cnt_q);
    ps_d  = boundary;
    if (boundary && !pend_full_q) begin
      und_d = 1'b1;
    end else if (clr_underrun) begin
      und_d = 1'b0;
    end else begin
      und_d = und_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      active_q    <= '0;
      pwm_q       <= 1'b0;
      ps_q        <= 1'b0;
      und_q       <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      active_q    <= active_d;
      pwm_q       <= pwm_d;
      ps_q        <= ps_d;
      und_q       <= und_d;
    end
  end

  assign pwm_out      = pwm_q;
  assign period_start = ps_q;
  assign underrun     = und_q;

endmodule

// File: tb/tb_pwm_dac_out.sv
// Self-checking bench for pwm_dac_out against a tick-count/queue reference model.
module tb_pwm_dac_out;

  localparam int WIDTH    = 8;
  localparam int PRESCALE = 1;
  localparam int PERIOD   = 255;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] sample = '0;
  logic       sample_valid = 1'b0;
  logic       sample_ready;
  logic [1:0] amp_shift = '0;
  logic       enable = 1'b0;
  logic       clr_underrun = 1'b0;
  logic       pwm_out;
  logic       period_start;
  logic       underrun;

  int errors = 0;
  int checks = 0;

  // reference model state
  int en_clks;
  int pend_q[$];
  int m_act;
  int m_accepts;
  bit m_pwm, m_ps, m_und, m_rdy;

  // observed duty per period (pwm highs over the 255 clks after period_start)
  bit win_on;
  int win, win_high;
  int duty_q[$];

  always #5 clk = ~clk;

  pwm_dac_out #(.WIDTH(WIDTH), .PRESCALE(PRESCALE)) dut (
    .clk          (clk),
    .rst          (rst),
    .sample       (sample),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .amp_shift    (amp_shift),
    .enable       (enable),
    .clr_underrun (clr_underrun),
    .pwm_out      (pwm_out),
    .period_start (period_start),
    .underrun     (underrun)
  );

  task automatic model_reset();
    en_clks   = 0;
    pend_q.delete();
    m_act     = 0;
    m_accepts = 0;
    m_pwm     = 0;
    m_ps      = 0;
    m_und     = 0;
    m_rdy     = 1;
    win_on    = 0;
    win       = 0;
    win_high  = 0;
    duty_q.delete();
  endtask

  // Advance one clk: update the model from the inputs seen at the edge, then
  // settle and record the observed duty window.
  task automatic cycle();
    int c;
    bit tk, bnd, acc, empty;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      c     = (en_clks / PRESCALE) % PERIOD;
      tk    = enable && ((en_clks % PRESCALE) == PRESCALE - 1);
      bnd   = tk && (c == PERIOD - 1);
      empty = (pend_q.size() == 0);
      acc   = sample_valid && empty;
      m_pwm = enable && (m_act > c);
      m_ps  = bnd;
      if (bnd && empty) m_und = 1;
      else if (clr_underrun) m_und = 0;
      if (bnd && !empty) m_act = pend_q.pop_front() >> amp_shift;
      if (acc) begin
        pend_q.push_back(int'(sample));
        m_accepts++;
      end
      if (enable) en_clks++;
      m_rdy = (pend_q.size() == 0);
    end
    #1;
    if (win_on) begin
      win++;
      win_high += int'(pwm_out);
      if (win == PERIOD) begin
        duty_q.push_back(win_high);
        win_on = 0;
      end
    end
    if (period_start === 1'b1) begin
      win_on   = 1;
      win      = 0;
      win_high = 0;
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    sample_valid = 1'b0;
    enable = 1'b0;
    clr_underrun = 1'b0;
    amp_shift = '0;
    sample = '0;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++;
    if ({pwm_out, period_start, underrun} !== 3'b000) begin
      errors++;
      $display("FAIL reset_outputs got pwm/ps/und=%b%b%b want 000", pwm_out, period_start, underrun);
    end
    checks++;
    if (sample_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got %b want 1", sample_ready);
    end
    apply_reset();
  endtask

  task automatic test_basic();
    apply_reset();
    sample = 8'd128; sample_valid = 1'b1; enable = 1'b1;
    cycle();
    checks++;
    if (sample_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_ready_drop got %b want 0", sample_ready);
    end
    for (int i = 0; i < 3*PERIOD + 5; i++) begin
      cycle();
      checks++;
      if ({pwm_out, period_start, underrun, sample_ready} !== {m_pwm, m_ps, m_und, m_rdy}) begin
        errors++;
        $display("FAIL basic_model t=%0t got pwm/ps/und/rdy=%b%b%b%b want %b%b%b%b", $time,
                 pwm_out, period_start, underrun, sample_ready, m_pwm, m_ps, m_und, m_rdy);
      end
    end
    checks++;
    if (duty_q.size() < 2 || duty_q[0] != 128 || duty_q[1] != 128) begin
      errors++;
      $display("FAIL basic_duty got %0d periods first=%0d want >=2 periods of 128 highs",
               duty_q.size(), (duty_q.size() > 0) ? duty_q[0] : -1);
    end
  endtask

  task automatic test_extremes();
    apply_reset();
    sample = 8'd0; sample_valid = 1'b1; enable = 1'b1;
    for (int i = 0; i < 3*PERIOD + 5; i++) begin
      cycle();
      checks++;
      if ({pwm_out, period_start, underrun, sample_ready} !== {m_pwm, m_ps, m_und, m_rdy}) begin
        errors++;
        $display("FAIL extremes_model t=%0t got pwm/ps/und/rdy=%b%b%b%b want %b%b%b%b", $time,
                 pwm_out, period_start, underrun, sample_ready, m_pwm, m_ps, m_und, m_rdy);
      end
      if (m_accepts >= 1) sample = 8'd255;
    end
    checks++;
    if (duty_q.size() < 2 || duty_q[0] != 0 || duty_q[1] != PERIOD) begin
      errors++;
      $display("FAIL extremes_duty got %0d periods [%0d,%0d] want [0,255]", duty_q.size(),
               (duty_q.size() > 0) ? duty_q[0] : -1, (duty_q.size() > 1) ? duty_q[1] : -1);
    end
    checks++;
    if (underrun !== 1'b0) begin
      errors++;
      $display("FAIL extremes_underrun got %b want 0", underrun);
    end
  endtask

  task automatic test_atten();
    apply_reset();
    sample = 8'd200; amp_shift = 2'd2; sample_valid = 1'b1; enable = 1'b1;
    for (int i = 0; i < 2*PERIOD + 5; i++) begin
      cycle();
      checks++;
      if ({pwm_out, period_start, underrun, sample_ready} !== {m_pwm, m_ps, m_und, m_rdy}) begin
        errors++;
        $display("FAIL atten_model t=%0t got pwm/ps/und/rdy=%b%b%b%b want %b%b%b%b", $time,
                 pwm_out, period_start, underrun, sample_ready, m_pwm, m_ps, m_und, m_rdy);
      end
    end
    checks++;
    if (duty_q.size() < 1 || duty_q[0] != 50) begin
      errors++;
      $display("FAIL atten_duty got %0d periods first=%0d want 50 highs",
               duty_q.size(), (duty_q.size() > 0) ? duty_q[0] : -1);
    end
  endtask

  task automatic test_underrun();
    apply_reset();
    sample = 8'd90; sample_valid = 1'b1; enable = 1'b1;
    cycle();
    sample_valid = 1'b0;
    for (int i = 0; i < 3*PERIOD + 5; i++) begin
      cycle();
      checks++;
      if ({pwm_out, period_start, underrun, sample_ready} !== {m_pwm, m_ps, m_und, m_rdy}) begin
        errors++;
        $display("FAIL underrun_model t=%0t got pwm/ps/und/rdy=%b%b%b%b want %b%b%b%b", $time,
                 pwm_out, period_start, underrun, sample_ready, m_pwm, m_ps, m_und, m_rdy);
      end
    end
    checks++;
    if (underrun !== 1'b1) begin
      errors++;
      $display("FAIL underrun_set got %b want 1", underrun);
    end
    checks++;
    if (duty_q.size() < 2 || duty_q[0] != 90 || duty_q[1] != 90) begin
      errors++;
      $display("FAIL underrun_repeat got %0d periods [%0d,%0d] want [90,90]", duty_q.size(),
               (duty_q.size() > 0) ? duty_q[0] : -1, (duty_q.size() > 1) ? duty_q[1] : -1);
    end
    clr_underrun = 1'b1;
    cycle();
    clr_underrun = 1'b0;
    checks++;
    if (underrun !== 1'b0) begin
      errors++;
      $display("FAIL underrun_clear got %b want 0", underrun);
    end
    for (int i = 0; i < PERIOD && (en_clks % PERIOD) != PERIOD - 1; i++) begin
      cycle();
      checks++;
      if ({pwm_out, period_start, underrun, sample_ready} !== {m_pwm, m_ps, m_und, m_rdy}) begin
        errors++;
        $display("FAIL underrun_wait t=%0t got pwm/ps/und/rdy=%b%b%b%b want %b%b%b%b", $time,
                 pwm_out, period_start, underrun, sample_ready, m_pwm, m_ps, m_und, m_rdy);
      end
    end
    clr_underrun = 1'b1;
    cycle();
    clr_underrun = 1'b0;
    checks++;
    if ({period_start, underrun} !== 2'b11) begin
      errors++;
      $display("FAIL underrun_set_wins got ps/und=%b%b want 11", period_start, underrun);
    end
  endtask

  task automatic test_enable_gap();
    int n;
    bit found;
    apply_reset();
    sample = 8'd180; sample_valid = 1'b1; enable = 1'b1;
    for (int i = 0; i < 2*PERIOD && !(en_clks >= PERIOD && (en_clks % PERIOD) == 100); i++) begin
      cycle();
      checks++;
      if ({pwm_out, period_start, underrun, sample_ready} !== {m_pwm, m_ps, m_und, m_rdy}) begin
        errors++;
        $display("FAIL gap_model t=%0t got pwm/ps/und/rdy=%b%b%b%b want %b%b%b%b", $time,
                 pwm_out, period_start, underrun, sample_ready, m_pwm, m_ps, m_und, m_rdy);
      end
    end
    enable = 1'b0;
    cycle();
    checks++;
    if (pwm_out !== 1'b0) begin
      errors++;
      $display("FAIL gap_pwm_low got %b want 0", pwm_out);
    end
    for (int i = 0; i < 19; i++) begin
      cycle();
      checks++;
      if ({pwm_out, period_start, underrun, sample_ready} !== {m_pwm, m_ps, m_und, m_rdy}) begin
        errors++;
        $display("FAIL gap_hold t=%0t got pwm/ps/und/rdy=%b%b%b%b want %b%b%b%b", $time,
                 pwm_out, period_start, underrun, sample_ready, m_pwm, m_ps, m_und, m_rdy);
      end
    end
    enable = 1'b1;
    n = 0;
    found = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      cycle();
      n++;
      if (period_start === 1'b1) found = 1;
    end
    checks++;
    if (!found || n != 155) begin
      errors++;
      $display("FAIL gap_resume got boundary after %0d clks (found=%0d) want 155", n, found);
    end
  endtask

  task automatic test_async_reset();
    int  n;
    bit  found, high_seen;
    apply_reset();
    sample = 8'd77; sample_valid = 1'b1; enable = 1'b1;
    for (int i = 0; i < PERIOD + 10; i++) begin
      cycle();
      checks++;
      if ({pwm_out, period_start, underrun, sample_ready} !== {m_pwm, m_ps, m_und, m_rdy}) begin
        errors++;
        $display("FAIL areset_model t=%0t got pwm/ps/und/rdy=%b%b%b%b want %b%b%b%b", $time,
                 pwm_out, period_start, underrun, sample_ready, m_pwm, m_ps, m_und, m_rdy);
      end
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({pwm_out, period_start, underrun, sample_ready} !== 4'b0001) begin
      errors++;
      $display("FAIL areset_immediate got pwm/ps/und/rdy=%b%b%b%b want 0001",
               pwm_out, period_start, underrun, sample_ready);
    end
    sample_valid = 1'b0;
    cycle();
    rst = 1'b0;
    n = 0;
    found = 0;
    high_seen = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      cycle();
      n++;
      if (pwm_out !== 1'b0) high_seen = 1;
      if (period_start === 1'b1) found = 1;
    end
    checks++;
    if (!found || n != PERIOD) begin
      errors++;
      $display("FAIL areset_first_boundary got %0d clks (found=%0d) want 255", n, found);
    end
    checks++;
    if (underrun !== 1'b1) begin
      errors++;
      $display("FAIL areset_underrun got %b want 1", underrun);
    end
    checks++;
    if (high_seen) begin
      errors++;
      $display("FAIL areset_active_zero got pwm high after reset want always low");
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 3000; i++) begin
      sample       = 8'($urandom);
      sample_valid = ($urandom_range(0, 9) < 7);
      amp_shift    = 2'($urandom_range(0, 3));
      enable       = ($urandom_range(0, 19) != 0);
      clr_underrun = ($urandom_range(0, 29) == 0);
      cycle();
      checks++;
      if ({pwm_out, period_start, underrun, sample_ready} !== {m_pwm, m_ps, m_und, m_rdy}) begin
        errors++;
        $display("FAIL random_model t=%0t got pwm/ps/und/rdy=%b%b%b%b want %b%b%b%b", $time,
                 pwm_out, period_start, underrun, sample_ready, m_pwm, m_ps, m_und, m_rdy);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_extremes();
    test_atten();
    test_underrun();
    test_enable_gap();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
